// File: rtl/vwiden_seq_if.sv
// Handshake bundle for the vector widening sequencer: source beat in, widened result beat out.
// slave is the sequencer's view, master is the surrounding issue/writeback view.
interface vwiden_seq_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned SEW_WIDTH  = 2,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [SEW_WIDTH-1:0]  in_sew;
    logic [BE_WIDTH-1:0]   in_be;
    logic                  in_signed;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [BE_WIDTH-1:0]   out_be;
    logic [SEW_WIDTH-1:0]  out_sew;
    logic                  out_turn;
    logic                  out_last;
    logic                  err_sew;

    modport slave (
        input  in_valid, in_data, in_sew, in_be, in_signed, in_last, out_ready,
        output in_ready, out_valid, out_data, out_be, out_sew, out_turn, out_last, err_sew
    );

    modport master (
        output in_valid, in_data, in_sew, in_be, in_signed, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_be, out_sew, out_turn, out_last, err_sew
    );
endinterface

// File: rtl/vwiden_seq.sv
// Widening sequencer: holds one source beat and emits its low then high half widened to 2*SEW.
// Optional VWIDEN_SEQ_SKIP_EMPTY_EN skips the high turn when its byte enables are all zero.
module vwiden_seq #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned SEW_WIDTH  = 2,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
    input logic         clk,
    input logic         rst,
    vwiden_seq_if.slave bus
);
    localparam int unsigned HalfW  = DATA_WIDTH / 2;
    localparam int unsigned HalfBe = BE_WIDTH / 2;

    typedef enum logic [1:0] {StIdle, StT0, StT1} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [SEW_WIDTH-1:0]  sew_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic                  signed_q;
    logic                  last_q;
    logic                  err_q;

    logic                  in_ready;
    logic                  accept;
    logic                  legal;
    logic                  skip_t1;
    logic                  turn;
    logic [HalfW-1:0]      half;
    logic [HalfBe-1:0]     half_be;
    logic [DATA_WIDTH-1:0] wide;
    logic [BE_WIDTH-1:0]   wide_be;

`ifdef VWIDEN_SEQ_SKIP_EMPTY_EN
    assign skip_t1 = ~|be_q[BE_WIDTH-1:HalfBe];
`else
    assign skip_t1 = 1'b0;
`endif

    // A new beat may enter whenever the last turn of the current one is being consumed.
    assign in_ready = (state_q == StIdle) ||
                      (bus.out_ready && ((state_q == StT1) || ((state_q == StT0) && skip_t1)));
    assign accept   = bus.in_valid && in_ready;
    assign legal    = (bus.in_sew != SEW_WIDTH'(3));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && legal) state_d = StT0;
            end
            StT0: begin
                if (bus.out_ready) begin
                    if (!skip_t1)            state_d = StT1;
                    else if (accept && legal) state_d = StT0;
                    else                     state_d = StIdle;
                end
            end
            StT1: begin
                if (bus.out_ready) state_d = (accept && legal) ? StT0 : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            data_q   <= '0;
            sew_q    <= '0;
            be_q     <= '0;
            signed_q <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= accept && !legal;
            if (accept) begin
                data_q   <= bus.in_data;
                sew_q    <= bus.in_sew;
                be_q     <= bus.in_be;
                signed_q <= bus.in_signed;
                last_q   <= bus.in_last;
            end
        end
    end

    assign turn    = (state_q == StT1);
    assign half    = turn ? data_q[DATA_WIDTH-1:HalfW] : data_q[HalfW-1:0];
    assign half_be = turn ? be_q[BE_WIDTH-1:HalfBe] : be_q[HalfBe-1:0];

    always_comb begin
        wide = '0;
        case (sew_q)
            SEW_WIDTH'(0): begin
                for (int e = 0; e < DATA_WIDTH / 16; e++) begin
                    wide[e*16 +: 16] = {{8{signed_q & half[e*8+7]}}, half[e*8 +: 8]};
                end
            end
            SEW_WIDTH'(1): begin
                for (int e = 0; e < DATA_WIDTH / 32; e++) begin
                    wide[e*32 +: 32] = {{16{signed_q & half[e*16+15]}}, half[e*16 +: 16]};
                end
            end
            SEW_WIDTH'(2): begin
                for (int e = 0; e < DATA_WIDTH / 64; e++) begin
                    wide[e*64 +: 64] = {{32{signed_q & half[e*32+31]}}, half[e*32 +: 32]};
                end
            end
            default: wide = '0;
        endcase
    end

    always_comb begin
        wide_be = '0;
        for (int k = 0; k < int'(HalfBe); k++) begin
            wide_be[2*k +: 2] = {2{half_be[k]}};
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q != StIdle);
    assign bus.out_data  = wide;
    assign bus.out_be    = wide_be;
    assign bus.out_sew   = sew_q + SEW_WIDTH'(1);
    assign bus.out_turn  = turn;
    assign bus.out_last  = last_q && (turn || ((state_q == StT0) && skip_t1));
    assign bus.err_sew   = err_q;
endmodule

// File: tb/tb_vwiden_seq.sv
// Directed bench for vwiden_seq: widening results, stalls, back-to-back beats, bad SEW, reset.
module tb_vwiden_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vwiden_seq_if #(.DATA_WIDTH(64), .SEW_WIDTH(2), .BE_WIDTH(8)) bus ();

    vwiden_seq #(.DATA_WIDTH(64), .SEW_WIDTH(2), .BE_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic [1:0] sew, input logic [7:0] be,
                        input logic sgn, input logic last);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_sew    = sew;
        bus.in_be     = be;
        bus.in_signed = sgn;
        bus.in_last   = last;
    endtask

    initial begin
        logic [63:0] d;
        int p;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sew    = '0;
        bus.in_be     = '0;
        bus.in_signed = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_err_sew", 64'(bus.err_sew), 64'd0);
        check("rst_out_turn", 64'(bus.out_turn), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        rst = 1'b0;
        tick();

        // SEW=8 signed
        send(64'hFE01_7F80_0000_807F, 2'd0, 8'hFF, 1'b1, 1'b0);
        check("t1_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check("t1_t0_valid", 64'(bus.out_valid), 64'd1);
        check("t1_t0_turn", 64'(bus.out_turn), 64'd0);
        check("t1_t0_data", bus.out_data, 64'h0000_0000_FF80_007F);
        check("t1_t0_sew", 64'(bus.out_sew), 64'd1);
        check("t1_t0_be", 64'(bus.out_be), 64'hFF);
        tick();
        check("t1_t1_turn", 64'(bus.out_turn), 64'd1);
        check("t1_t1_data", bus.out_data, 64'hFFFE_0001_007F_FF80);
        check("t1_t1_last", 64'(bus.out_last), 64'd0);
        tick();
        check("t1_idle", 64'(bus.out_valid), 64'd0);

        // SEW=32 unsigned with output stall in T0
        bus.out_ready = 1'b0;
        send(64'hFFFF_FFFF_0000_0001, 2'd2, 8'h96, 1'b0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_valid", 64'(bus.out_valid), 64'd1);
            check("t3_stall_data", bus.out_data, 64'h0000_0000_0000_0001);
            check("t3_stall_be", 64'(bus.out_be), 64'h3C);
            check("t3_stall_turn", 64'(bus.out_turn), 64'd0);
            check("t3_stall_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        check("t3_release_data", bus.out_data, 64'h0000_0000_0000_0001);
        tick();
        check("t3_t1_turn", 64'(bus.out_turn), 64'd1);
        check("t3_t1_data", bus.out_data, 64'h0000_0000_FFFF_FFFF);
        check("t3_t1_be", 64'(bus.out_be), 64'hC3);
        check("t3_t1_sew", 64'(bus.out_sew), 64'd3);
        check("t3_t1_last", 64'(bus.out_last), 64'd1);
        tick();
        check("t3_idle", 64'(bus.out_valid), 64'd0);

        // Three back-to-back beats, SEW=8 unsigned
        for (int c = 0; c <= 7; c++) begin
            p = (c + 1) / 2;
            if (c == 0) p = 0;
            if (p < 3) begin
                d = (64'(16 + p) << 32) | 64'(p + 1);
                send(d, 2'd0, 8'hFF, 1'b0, (p == 2));
            end else begin
                bus.in_valid = 1'b0;
            end
            if (c >= 1 && c <= 6) begin
                check("t4_valid", 64'(bus.out_valid), 64'd1);
                check("t4_turn", 64'(bus.out_turn), 64'((c - 1) % 2));
                check("t4_data", bus.out_data,
                      ((c - 1) % 2 == 0) ? 64'((c - 1) / 2 + 1) : 64'(16 + (c - 1) / 2));
                check("t4_last", 64'(bus.out_last), 64'(c == 6));
                check("t4_in_ready", 64'(bus.in_ready), 64'(c % 2 == 0));
            end
            if (c == 7) check("t4_idle", 64'(bus.out_valid), 64'd0);
            tick();
        end
        bus.in_valid = 1'b0;

        // Illegal SEW from idle, then a normal SEW=16 signed beat, then illegal SEW in T1
        send(64'h1234_5678_9ABC_DEF0, 2'd3, 8'hFF, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check("t5_err_pulse", 64'(bus.err_sew), 64'd1);
        check("t5_no_valid", 64'(bus.out_valid), 64'd0);
        tick();
        check("t5_err_clear", 64'(bus.err_sew), 64'd0);
        check("t5_no_valid2", 64'(bus.out_valid), 64'd0);
        send(64'h0000_0000_8000_7FFF, 2'd1, 8'hFF, 1'b1, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check("t5_next_data", bus.out_data, 64'hFFFF_8000_0000_7FFF);
        check("t5_next_sew", 64'(bus.out_sew), 64'd2);
        check("t5_next_err", 64'(bus.err_sew), 64'd0);
        tick();
        check("t5_next_turn", 64'(bus.out_turn), 64'd1);
        send(64'h0, 2'd3, 8'hFF, 1'b0, 1'b0);
        check("t5_t1_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check("t5_t1_err", 64'(bus.err_sew), 64'd1);
        check("t5_t1_idle", 64'(bus.out_valid), 64'd0);
        tick();

        // Reset while in T1
        send(64'hAAAA_AAAA_5555_5555, 2'd0, 8'hFF, 1'b0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("t6_in_t1", 64'(bus.out_turn), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        check("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("t6_rst_turn", 64'(bus.out_turn), 64'd0);
        check("t6_rst_last", 64'(bus.out_last), 64'd0);
        tick();
        check("t6_rst_stays_idle", 64'(bus.out_valid), 64'd0);

        // Beat with empty high-half byte enables
        send(64'h0000_0000_0000_0000, 2'd0, 8'h0F, 1'b0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("t6_be_t0", 64'(bus.out_be), 64'hFF);
`ifdef VWIDEN_SEQ_SKIP_EMPTY_EN
        check("t6_skip_last", 64'(bus.out_last), 64'd1);
        check("t6_skip_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        check("t6_skip_idle", 64'(bus.out_valid), 64'd0);
`else
        check("t6_t0_last", 64'(bus.out_last), 64'd0);
        tick();
        check("t6_t1_turn", 64'(bus.out_turn), 64'd1);
        check("t6_t1_be", 64'(bus.out_be), 64'h00);
        check("t6_t1_last", 64'(bus.out_last), 64'd1);
        tick();
        check("t6_idle", 64'(bus.out_valid), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
